seg7_disp_ctrl: RTL
===================

SEG7_DISP_CTRL -- requirements
Module: seg7_disp_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clk cycles per display second; legal values are 8 or greater and divisible by 4.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_req  input  1  start request; sampled only while o_ready=1.
REQ-005 i_req_type  input  1  0=operator show, 1=countdown.
REQ-006 i_op_code  input  3  operator code to display; latched on accept.
REQ-007 i_cnt_init  input  4  countdown start value, or operator-show duration in seconds; latched on accept.
REQ-008 i_abort  input  1  cancel the current job.
REQ-009 o_ready  output  1  high only in IDLE.
REQ-010 o_done  output  1  one-cycle pulse at normal job completion.
REQ-011 o_en  output  1  display enable to the seven-segment driver.
REQ-012 o_disp_mode  output  1  0=operator symbol, 1=numeric digit.
REQ-013 o_op_code  output  3  latched operator code.
REQ-014 o_digit_val  output  4  remaining countdown value, 0..15.

Function
REQ-015 FSM states SHALL be IDLE, SHOW_OP, COUNT and DONE; all outputs SHALL be registered.
REQ-016 A prescaler SHALL count 0..CLK_FREQ-1 and raise sec_tick when it equals CLK_FREQ-1, then wrap to 0.
REQ-017 The prescaler SHALL clear to 0 on request accept.
REQ-018 IDLE: o_ready=1 and o_en=0; i_req=1 with i_abort=0 SHALL be accepted, latching type, op code and init.
REQ-019 Accept latency: accepted in cycle k, the new state and outputs SHALL be visible in cycle k+1.
REQ-020 SHOW_OP: o_en=1, o_disp_mode=0, o_op_code=latched value.
REQ-021 SHOW_OP SHALL last max(i_cnt_init,1) seconds, that is max(init,1)*CLK_FREQ cycles, then enter DONE.
REQ-022 COUNT: o_en=1, o_disp_mode=1, o_digit_val starts at the latched init value.
REQ-023 COUNT: o_digit_val SHALL decrement by 1 on each sec_tick while nonzero.
REQ-024 COUNT: sec_tick with o_digit_val=0 SHALL enter DONE; total time is (init+1)*CLK_FREQ cycles, and there is no wrap below 0.
REQ-025 DONE SHALL last exactly one cycle with o_done=1, o_en=0 and o_ready=0, then enter IDLE.
REQ-026 i_req while o_ready=0, including in DONE, SHALL be ignored and not queued.
REQ-027 i_abort=1 in SHOW_OP or COUNT SHALL force IDLE next cycle with o_en=0 and no o_done pulse; abort SHALL have priority over a coincident sec_tick.
REQ-028 i_abort=1 in IDLE SHALL block acceptance of a coincident i_req.
REQ-029 i_abort=1 in DONE SHALL have no effect; o_done SHALL still pulse.
REQ-030 In IDLE, o_digit_val and o_op_code SHALL hold their last values; o_disp_mode SHALL be 0.

Reset
REQ-031 rst_n=0 on a clk edge SHALL force IDLE, prescaler=0, o_ready=1 and all other outputs 0.
REQ-032 Reset asserted mid-job SHALL abandon the job without an o_done pulse.
REQ-033 After reset release, a request SHALL be acceptable on the first clk edge.

Configuration
REQ-034 The macro DISP_BLINK_EN, when defined, SHALL make o_en in SHOW_OP toggle every CLK_FREQ/4 cycles, 2 Hz, starting high on entry.
REQ-035 With DISP_BLINK_EN defined, the blink phase counter SHALL restart on each SHOW_OP entry; COUNT SHALL be unaffected.
REQ-036 Without DISP_BLINK_EN, o_en SHALL be steady high in SHOW_OP and no blink logic SHALL be synthesized.

Verification (CLK_FREQ=8)
REQ-037 Reset: rst_n low 2 cycles mid-COUNT -> o_ready=1, o_en=0, o_digit_val=0, o_done never high.
REQ-038 Countdown: i_req_type=1, i_cnt_init=3, accepted cycle 0 -> o_digit_val 3,2,1,0 for 8 cycles each (cycles 1-32), o_done=1 in cycle 33, o_ready=1 in cycle 34.
REQ-039 Operator show: i_req_type=0, i_op_code=2, i_cnt_init=0 -> o_disp_mode=0, o_op_code=2, o_en=1 in cycles 1-8, o_done in cycle 9.
REQ-040 Abort: i_abort=1 in cycle 12 of a countdown with init=5 -> IDLE and o_en=0 in cycle 13, no o_done pulse.
REQ-041 Busy and collision: second i_req in cycle 4 and i_req in the DONE cycle -> both ignored; a single o_done pulse.
REQ-042 With DISP_BLINK_EN defined, op show with i_cnt_init=1 -> o_en pattern 1,1,0,0,1,1,0,0 over cycles 1-8.

Source files
------------

// File: rtl/seg7_disp_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_disp_ctrl
//
// Job controller for a seven-segment display driver. A job either shows an
// operator symbol for a number of seconds, or counts a digit down from a
// start value once per second. One-second ticks come from an internal
// prescaler of CLK_FREQ clock cycles.
//
// Configuration macro:
//   DISP_BLINK_EN  - when defined, o_en blinks at 2 Hz while an operator
//                    symbol is shown (toggle every CLK_FREQ/4 cycles,
//                    starting high). Undefined: o_en steady, no blink logic.
//
// Parameters:
//   CLK_FREQ     - clk cycles per display second (>= 8, divisible by 4)
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - synchronous active-low reset
//   i_req        - start request, sampled only while o_ready=1
//   i_req_type   - 0 = operator show, 1 = countdown
//   i_op_code    - operator code, latched on accept
//   i_cnt_init   - countdown start / show duration in seconds, latched
//   i_abort      - cancel the running job (no o_done pulse)
//   o_ready      - high only in IDLE
//   o_done       - one-cycle pulse on normal completion
//   o_en         - display enable
//   o_disp_mode  - 0 = operator symbol, 1 = numeric digit
//   o_op_code    - latched operator code
//   o_digit_val  - remaining countdown value
// ---------------------------------------------------------------------------
module seg7_disp_ctrl #(
    parameter int CLK_FREQ = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req,
    input  logic       i_req_type,
    input  logic [2:0] i_op_code,
    input  logic [3:0] i_cnt_init,
    input  logic       i_abort,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_en,
    output logic       o_disp_mode,
    output logic [2:0] o_op_code,
    output logic [3:0] o_digit_val
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHOW_OP = 2'd1;
    localparam logic [1:0] S_COUNT   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int                 PRESC_W   = $clog2(CLK_FREQ);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ - 1);

`ifdef DISP_BLINK_EN
    localparam int                 BLINK_Q   = CLK_FREQ / 4;
    localparam int                 BLINK_W   = $clog2(BLINK_Q);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_Q - 1);

    logic [BLINK_W-1:0] blink_cnt;
`endif

    logic [1:0]         state;
    logic [PRESC_W-1:0] presc;
    logic [3:0]         sec_left;   // remaining seconds of an operator show
    logic               sec_tick;
    logic               accept;

    assign sec_tick = (presc == PRESC_MAX);
    assign accept   = (state == S_IDLE) && i_req && !i_abort;

    // NOTE: every register below is written with <= so that all of them
    // update from the same pre-edge values; mixing in = would make the
    // result depend on statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            presc       <= '0;
            sec_left    <= '0;
            o_ready     <= 1'b1;
            o_done      <= 1'b0;
            o_en        <= 1'b0;
            o_disp_mode <= 1'b0;
            o_op_code   <= '0;
            o_digit_val <= '0;
`ifdef DISP_BLINK_EN
            blink_cnt   <= '0;
`endif
        end else begin
            // Free-running seconds prescaler, realigned on every accept so
            // the first second of a job is a full CLK_FREQ cycles.
            if (accept || sec_tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end

            // o_done is a pulse: low unless the DONE entry below raises it.
            o_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        o_ready   <= 1'b0;
                        o_en      <= 1'b1;
                        o_op_code <= i_op_code;
                        if (i_req_type) begin
                            state       <= S_COUNT;
                            o_disp_mode <= 1'b1;
                            o_digit_val <= i_cnt_init;
                        end else begin
                            state       <= S_SHOW_OP;
                            o_disp_mode <= 1'b0;
                            // A zero duration still shows for one second.
                            sec_left    <= (i_cnt_init == 4'd0) ? 4'd1 : i_cnt_init;
`ifdef DISP_BLINK_EN
                            blink_cnt   <= '0;
`endif
                        end
                    end
                end

                S_SHOW_OP: begin
`ifdef DISP_BLINK_EN
                    // Blink first; abort/completion below override o_en.
                    if (blink_cnt == BLINK_MAX) begin
                        blink_cnt <= '0;
                        o_en      <= ~o_en;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
`endif
                    if (i_abort) begin
                        state       <= S_IDLE;
                        o_ready     <= 1'b1;
                        o_en        <= 1'b0;
                        o_disp_mode <= 1'b0;
                    end else if (sec_tick) begin
                        if (sec_left == 4'd1) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_en   <= 1'b0;
                        end else begin
                            sec_left <= sec_left - 4'd1;
                        end
                    end
                end

                S_COUNT: begin
                    // Abort wins over a coincident tick.
                    if (i_abort) begin
                        state       <= S_IDLE;
                        o_ready     <= 1'b1;
                        o_en        <= 1'b0;
                        o_disp_mode <= 1'b0;
                    end else if (sec_tick) begin
                        if (o_digit_val == 4'd0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_en   <= 1'b0;
                        end else begin
                            o_digit_val <= o_digit_val - 4'd1;
                        end
                    end
                end

                S_DONE: begin
                    // Single cycle; requests and aborts here are ignored.
                    state       <= S_IDLE;
                    o_ready     <= 1'b1;
                    o_disp_mode <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    o_ready <= 1'b1;
                    o_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
